regfile_mp: RTL and testbench

Parametrised multi-port register file, the next generation of the single-write, dual-read CPU register file.
- Configurable read-port and write-port counts.
- Hardwired zero register.
- Optional write-to-read bypass.
- Synchronous active-low reset that sweep-clears the array with a counter-driven FSM, so no $readmemh initialisation is needed.
- Sits between decode and ALU. Exports a debug tap (default a0) to the testbench/top.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/rf_read_port.sv | 49 ++++
 rtl/regfile_mp.sv | 102 ++++++++++
 tb/tb_regfile_mp.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file.
package regfile_pkg;

  typedef enum logic [1:0] {
    RF_RESET = 2'd0,
    RF_CLEAR = 2'd1,
    RF_READY = 2'd2
  } rf_state_t;

  localparam int unsigned ZERO_REG = 0;
  localparam int unsigned A0_REG   = 10;

endpackage

// File: rtl/rf_read_port.sv
// One registered read port: bypass from the same-cycle write ports and zero-register forcing.
module rf_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NUM_WR = 1,
  parameter int unsigned BYPASS = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_en,
  input  logic [ADDR_W-1:0]        i_rd_addr,
  input  logic [DATA_W-1:0]        i_rd_val,
  input  logic [NUM_WR-1:0]        i_wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] i_wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] i_wr_data,
  output logic [DATA_W-1:0]        o_rd_data
);

  logic [DATA_W-1:0] r_rd_data;
  logic [DATA_W-1:0] w_rd_next;

  // Later ports overwrite earlier matches, so the highest-index writer wins.
  always_comb begin
    w_rd_next = i_rd_val;
    if (BYPASS != 0) begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (i_wr_en[j] && (i_wr_addr[j*ADDR_W +: ADDR_W] == i_rd_addr)) begin
          w_rd_next = i_wr_data[j*DATA_W +: DATA_W];
        end
      end
    end
    if (i_rd_addr == ADDR_W'(ZERO_REG)) begin
      w_rd_next = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || !i_en) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= w_rd_next;
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with hardwired zero register and a post-reset clear sweep.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 1,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned DBG_REG  = A0_REG
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0] o_rd_data,
  input  logic [NUM_WR-1:0]        i_wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] i_wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] i_wr_data,
  output logic                     o_ready,
  output logic [DATA_W-1:0]        o_dbg_data
);

  rf_state_t         r_state, w_state_next;
  logic [ADDR_W-1:0] r_clr_cnt, w_clr_cnt_next;
  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [DATA_W-1:0] r_dbg_data;
  logic              w_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= RF_RESET;
      r_clr_cnt <= ADDR_W'(1);
    end else begin
      r_state   <= w_state_next;
      r_clr_cnt <= w_clr_cnt_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_clr_cnt_next = r_clr_cnt;
    unique case (r_state)
      RF_RESET: w_state_next = RF_CLEAR;
      RF_CLEAR: begin
        if (r_clr_cnt == ADDR_W'(NUM_REGS - 1)) begin
          w_state_next = RF_READY;
        end else begin
          w_clr_cnt_next = r_clr_cnt + ADDR_W'(1);
        end
      end
      RF_READY: w_state_next = RF_READY;
      default:  w_state_next = RF_RESET;
    endcase
  end

  assign w_ready = (r_state == RF_READY);
  assign o_ready = w_ready;

  // Entry 0 is never written; every reader masks it to zero.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && (r_state == RF_CLEAR)) begin
      r_regs[r_clr_cnt] <= '0;
    end else if (i_rst_n && w_ready) begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (i_wr_en[j] && (i_wr_addr[j*ADDR_W +: ADDR_W] != ADDR_W'(ZERO_REG))) begin
          r_regs[i_wr_addr[j*ADDR_W +: ADDR_W]] <= i_wr_data[j*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || !w_ready || (DBG_REG == ZERO_REG)) begin
      r_dbg_data <= '0;
    end else begin
      r_dbg_data <= r_regs[DBG_REG];
    end
  end

  assign o_dbg_data = r_dbg_data;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    rf_read_port #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .NUM_WR (NUM_WR),
      .BYPASS (BYPASS)
    ) u_rd (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_en      (w_ready),
      .i_rd_addr (i_rd_addr[i*ADDR_W +: ADDR_W]),
      .i_rd_val  (r_regs[i_rd_addr[i*ADDR_W +: ADDR_W]]),
      .i_wr_en   (i_wr_en),
      .i_wr_addr (i_wr_addr),
      .i_wr_data (i_wr_data),
      .o_rd_data (o_rd_data[i*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: bypassing and non-bypassing instances share stimulus against one model.
module tb_regfile_mp;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 2;
  localparam int NW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR*AW-1:0] rd_addr = '0;
  logic [NW-1:0]    wr_en   = '0;
  logic [NW*AW-1:0] wr_addr = '0;
  logic [NW*DW-1:0] wr_data = '0;
  logic [NR*DW-1:0] rd_data, rd_data_nb;
  logic             ready, ready_nb;
  logic [DW-1:0]    dbg, dbg_nb;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] mdl [32];
  logic [DW-1:0] exp_rd [NR];
  logic [DW-1:0] exp_rd_nb [NR];
  logic [DW-1:0] exp_dbg;

  regfile_mp #(.NUM_WR(NW), .BYPASS(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rd_addr(rd_addr), .o_rd_data(rd_data),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .o_ready(ready), .o_dbg_data(dbg)
  );

  regfile_mp #(.NUM_WR(NW), .BYPASS(0)) dut_nb (
    .i_clk(clk), .i_rst_n(rst_n), .i_rd_addr(rd_addr), .o_rd_data(rd_data_nb),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .o_ready(ready_nb), .o_dbg_data(dbg_nb)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One READY-state cycle: predicts outputs from the model, clocks, then commits writes.
  task automatic drive_cycle(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                             input logic [1:0] we, input logic [AW-1:0] wa0,
                             input logic [AW-1:0] wa1, input logic [DW-1:0] wd0,
                             input logic [DW-1:0] wd1);
    logic [AW-1:0] ra [NR];
    logic [AW-1:0] wa [NW];
    logic [DW-1:0] wd [NW];
    ra[0] = ra0; ra[1] = ra1;
    wa[0] = wa0; wa[1] = wa1;
    wd[0] = wd0; wd[1] = wd1;
    rd_addr = {ra1, ra0};
    wr_en   = we;
    wr_addr = {wa1, wa0};
    wr_data = {wd1, wd0};
    for (int i = 0; i < NR; i++) begin
      exp_rd_nb[i] = (ra[i] == 0) ? '0 : mdl[ra[i]];
      exp_rd[i]    = exp_rd_nb[i];
      for (int j = 0; j < NW; j++) begin
        if (we[j] && wa[j] != 0 && wa[j] == ra[i]) exp_rd[i] = wd[j];
      end
    end
    exp_dbg = mdl[10];
    tick();
    for (int j = 0; j < NW; j++) begin
      if (we[j] && wa[j] != 0) mdl[wa[j]] = wd[j];
    end
    wr_en = '0;
  endtask

  task automatic release_and_clear(input string name);
    rst_n = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      wr_en   = 2'b11;
      wr_addr = NW*AW'($urandom);
      wr_data = {$urandom, $urandom};
      rd_addr = NR*AW'($urandom);
      tick();
      n_checks++;
      if (ready !== (e == 32) || ready_nb !== (e == 32)) begin
        $display("FAIL %s ready edge %0d: got %b/%b want %b", name, e, ready, ready_nb, e == 32);
      end else n_pass++;
      n_checks++;
      if (rd_data !== '0 || rd_data_nb !== '0 || dbg !== '0 || dbg_nb !== '0) begin
        $display("FAIL %s outputs held edge %0d: got rd %h/%h dbg %h/%h want 0",
                 name, e, rd_data, rd_data_nb, dbg, dbg_nb);
      end else n_pass++;
    end
    wr_en = '0;
    for (int a = 0; a < 32; a++) mdl[a] = '0;
  endtask

  task automatic read_all_zero(input string name);
    for (int a = 0; a < 32; a += 2) begin
      drive_cycle(AW'(a), AW'(a + 1), 2'b00, '0, '0, '0, '0);
      n_checks++;
      if (rd_data !== '0 || rd_data_nb !== '0) begin
        $display("FAIL %s regs %0d/%0d: got %h/%h want 0", name, a, a + 1, rd_data, rd_data_nb);
      end else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (ready !== 1'b0 || rd_data !== '0 || dbg !== '0 || ready_nb !== 1'b0) begin
      $display("FAIL reset_hold: got ready %b rd %h dbg %h want 0/0/0", ready, rd_data, dbg);
    end else n_pass++;
    release_and_clear("reset_clear");
    read_all_zero("reset_read");
  endtask

  task automatic test_basic();
    drive_cycle(5'd0, 5'd0, 2'b01, 5'd5, 5'd0, 32'hDEADBEEF, '0);
    drive_cycle(5'd5, 5'd0, 2'b00, '0, '0, '0, '0);
    n_checks++;
    if (rd_data !== {32'h0, 32'hDEADBEEF} || rd_data_nb !== {32'h0, 32'hDEADBEEF}) begin
      $display("FAIL basic_rw: got %h/%h want 00000000deadbeef", rd_data, rd_data_nb);
    end else n_pass++;
  endtask

  task automatic test_bypass();
    drive_cycle(5'd7, 5'd5, 2'b01, 5'd7, 5'd0, 32'h12345678, '0);
    n_checks++;
    if (rd_data !== {32'hDEADBEEF, 32'h12345678}) begin
      $display("FAIL bypass_on: got %h want deadbeef12345678", rd_data);
    end else n_pass++;
    n_checks++;
    if (rd_data_nb !== {32'hDEADBEEF, 32'h0}) begin
      $display("FAIL bypass_off: got %h want deadbeef00000000", rd_data_nb);
    end else n_pass++;
  endtask

  task automatic test_x0();
    drive_cycle(5'd0, 5'd0, 2'b11, 5'd0, 5'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    n_checks++;
    if (rd_data !== '0 || rd_data_nb !== '0) begin
      $display("FAIL x0_same_cycle: got %h/%h want 0", rd_data, rd_data_nb);
    end else n_pass++;
    drive_cycle(5'd0, 5'd0, 2'b00, '0, '0, '0, '0);
    n_checks++;
    if (rd_data !== '0 || rd_data_nb !== '0) begin
      $display("FAIL x0_later: got %h/%h want 0", rd_data, rd_data_nb);
    end else n_pass++;
  endtask

  task automatic test_collision_dbg();
    drive_cycle(5'd3, 5'd0, 2'b11, 5'd3, 5'd3, 32'hAAAA, 32'h5555);
    n_checks++;
    if (rd_data[DW-1:0] !== 32'h5555 || rd_data_nb[DW-1:0] !== 32'h0) begin
      $display("FAIL collision_bypass: got %h/%h want 5555/0",
               rd_data[DW-1:0], rd_data_nb[DW-1:0]);
    end else n_pass++;
    drive_cycle(5'd0, 5'd3, 2'b00, '0, '0, '0, '0);
    n_checks++;
    if (rd_data[2*DW-1:DW] !== 32'h5555 || rd_data_nb[2*DW-1:DW] !== 32'h5555) begin
      $display("FAIL collision_stored: got %h/%h want 5555",
               rd_data[2*DW-1:DW], rd_data_nb[2*DW-1:DW]);
    end else n_pass++;
    drive_cycle(5'd0, 5'd0, 2'b01, 5'd10, 5'd0, 32'h42, '0);
    n_checks++;
    if (dbg !== 32'h0 || dbg_nb !== 32'h0) begin
      $display("FAIL dbg_one_edge: got %h/%h want 0", dbg, dbg_nb);
    end else n_pass++;
    drive_cycle(5'd0, 5'd0, 2'b00, '0, '0, '0, '0);
    n_checks++;
    if (dbg !== 32'h42 || dbg_nb !== 32'h42) begin
      $display("FAIL dbg_two_edges: got %h/%h want 42", dbg, dbg_nb);
    end else n_pass++;
  endtask

  task automatic test_random();
    logic [AW-1:0] wa0, wa1;
    for (int c = 0; c < 300; c++) begin
      wa0 = AW'($urandom);
      wa1 = ($urandom_range(0, 3) == 0) ? wa0 : AW'($urandom);
      drive_cycle(($urandom_range(0, 1) == 0) ? wa0 : AW'($urandom), AW'($urandom),
                  2'($urandom), wa0, wa1, $urandom, $urandom);
      for (int i = 0; i < NR; i++) begin
        n_checks++;
        if (rd_data[i*DW +: DW] !== exp_rd[i] || rd_data_nb[i*DW +: DW] !== exp_rd_nb[i]) begin
          $display("FAIL random_rd%0d cycle %0d: got %h/%h want %h/%h", i, c,
                   rd_data[i*DW +: DW], rd_data_nb[i*DW +: DW], exp_rd[i], exp_rd_nb[i]);
        end else n_pass++;
      end
      n_checks++;
      if (dbg !== exp_dbg || dbg_nb !== exp_dbg) begin
        $display("FAIL random_dbg cycle %0d: got %h/%h want %h", c, dbg, dbg_nb, exp_dbg);
      end else n_pass++;
    end
  endtask

  task automatic test_reset_mid_clear();
    for (int a = 0; a < 32; a += 2) begin
      drive_cycle('0, '0, 2'b11, AW'(a), AW'(a + 1), 32'hFF, 32'hFF);
    end
    drive_cycle(5'd31, 5'd0, 2'b00, '0, '0, '0, '0);
    n_checks++;
    if (rd_data !== {32'h0, 32'hFF}) begin
      $display("FAIL fill: got %h want 00000000000000ff", rd_data);
    end else n_pass++;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    n_checks++;
    if (ready !== 1'b0 || ready_nb !== 1'b0 || rd_data !== '0) begin
      $display("FAIL midclear_reset: got ready %b rd %h want 0/0", ready, rd_data);
    end else n_pass++;
    release_and_clear("midclear_clear");
    read_all_zero("midclear_read");
  endtask

  initial begin
    for (int a = 0; a < 32; a++) mdl[a] = '0;
    test_reset();
    test_basic();
    test_bypass();
    test_x0();
    test_collision_dbg();
    test_random();
    test_reset_mid_clear();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
